alu_cmd_issuer: RTL and testbench

//  Initiator side of the ALU: receives 9-byte command frames on a byte stream (valid/ready),

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_cmd_issuer_if.sv | 23 ++
 rtl/alu_frame_timer.sv | 19 +
 rtl/alu_cmd_issuer.sv | 76 +++++++
 tb/tb_alu_cmd_issuer.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, status codes, FSM states and frame lengths shared by the ALU command issuer
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'b1010;
  localparam logic [3:0] OP_SUB  = 4'b1011;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b1101;
  localparam logic [3:0] OP_NOT  = 4'b1110;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_XNOR = 4'b0110;
  localparam logic [3:0] OP_ROR  = 4'b0111;
  localparam logic [7:0] ST_OK    = 8'h00;
  localparam logic [7:0] ST_BADOP = 8'h01;
  localparam int CMD_LEN = 9;
  localparam int RSP_LEN = 5;
  typedef enum logic [2:0] {RX_OP, RX_A, RX_B, EXEC, TX} state_t;
  function automatic logic op_legal(input logic [7:0] b);
    return b[7:4] == 4'h0 && b[3:0] inside {OP_ADD, OP_SUB, OP_OR, OP_AND, OP_NOT, OP_XOR, OP_XNOR, OP_ROR};
  endfunction
endpackage

// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if: inbound/outbound byte streams, ALU port bundle and status flags
interface alu_cmd_issuer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;
  logic        busy;
  logic        frame_err;
  modport master (
    input  in_data, in_valid, out_ready, alu_out,
    output in_ready, out_data, out_valid, alu_a, alu_b, alu_op, busy, frame_err
  );
  modport slave (
    output in_data, in_valid, out_ready, alu_out,
    input  in_ready, out_data, out_valid, alu_a, alu_b, alu_op, busy, frame_err
  );
endinterface

// File: rtl/alu_frame_timer.sv
// alu_frame_timer: counts idle cycles while enabled; pulses o_expire on the TIMEOUT-th idle cycle (TIMEOUT=0 disables)
module alu_frame_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);
  localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  logic [W-1:0] r_cnt;
  assign o_expire = (TIMEOUT != 0) && i_en && !i_clr && r_cnt == LAST;
  always_ff @(posedge clk) begin
    if (rst || i_clr || !i_en || o_expire) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: assembles 9-byte command frames, drives the external ALU, returns 5-byte status+result frames
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 1000
) (
  input logic clk,
  input logic rst,
  alu_cmd_issuer_if.master bus
);
  state_t      r_state, w_next;
  logic [1:0]  r_cnt;
  logic [31:0] r_a, r_b, r_res;
  logic [3:0]  r_op;
  logic [7:0]  r_status;
  logic        r_bad, r_hdr, r_err;
  logic        w_acc, w_emit, w_exp, w_rx;
  assign w_rx          = r_state inside {RX_A, RX_B};
  assign bus.in_ready  = r_state inside {RX_OP, RX_A, RX_B};
  assign bus.out_valid = r_state == TX;
  assign bus.out_data  = r_state != TX ? 8'h00 : r_hdr ? r_res[{r_cnt, 3'b000} +: 8] : r_status;
  assign bus.alu_a     = r_a;
  assign bus.alu_b     = r_b;
  assign bus.alu_op    = r_op;
  assign bus.busy      = r_state != RX_OP;
  assign bus.frame_err = r_err;
  assign w_acc         = bus.in_valid && bus.in_ready;
  assign w_emit        = bus.out_valid && bus.out_ready;
  alu_frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk), .rst(rst), .i_en(w_rx), .i_clr(w_acc), .o_expire(w_exp)
  );
  always_ff @(posedge clk) begin
    if (rst) r_state <= RX_OP;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RX_OP:   w_next = w_acc ? RX_A : RX_OP;
      RX_A:    w_next = w_acc ? (r_cnt == 2'd3 ? RX_B : RX_A) : w_exp ? RX_OP : RX_A;
      RX_B:    w_next = w_acc ? (r_cnt == 2'd3 ? EXEC : RX_B) : w_exp ? RX_OP : RX_B;
      EXEC:    w_next = TX;
      TX:      w_next = w_emit && r_hdr && r_cnt == 2'd3 ? RX_OP : TX;
      default: w_next = RX_OP;
    endcase
  end
  // r_cnt tracks operand bytes in RX_A/RX_B and result bytes after the status byte in TX
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_bad    <= 1'b0;
      r_res    <= '0;
      r_status <= ST_OK;
      r_hdr    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_exp;
      if (w_acc && r_state == RX_OP) begin
        r_op  <= op_legal(bus.in_data) ? bus.in_data[3:0] : 4'b0000;
        r_bad <= !op_legal(bus.in_data);
      end
      if (w_acc && r_state == RX_A) r_a <= {bus.in_data, r_a[31:8]};
      if (w_acc && r_state == RX_B) r_b <= {bus.in_data, r_b[31:8]};
      if ((w_acc && w_rx) || (w_emit && r_hdr)) r_cnt <= r_cnt + 2'd1;
      else if (w_exp) r_cnt <= '0;
      if (r_state == EXEC) begin
        r_res    <= r_bad ? 32'h0 : bus.alu_out;
        r_status <= r_bad ? ST_BADOP : ST_OK;
        r_hdr    <= 1'b0;
      end else if (w_emit && !r_hdr) r_hdr <= 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: table-driven frame vectors plus backpressure, timeout and reset sequences
module tb_alu_cmd_issuer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  alu_cmd_issuer_if bus();
  alu_cmd_issuer #(.TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  // reference ALU; unknown ops give a nonzero value so forcing of illegal results is visible
  assign bus.alu_out = bus.alu_op == 4'hA ? bus.alu_a + bus.alu_b :
                       bus.alu_op == 4'hB ? bus.alu_a - bus.alu_b :
                       bus.alu_op == 4'h2 ? bus.alu_a | bus.alu_b :
                       bus.alu_op == 4'hD ? bus.alu_a & bus.alu_b :
                       bus.alu_op == 4'hE ? ~bus.alu_a :
                       bus.alu_op == 4'h5 ? bus.alu_a ^ bus.alu_b :
                       bus.alu_op == 4'h6 ? ~(bus.alu_a ^ bus.alu_b) :
                       bus.alu_op == 4'h7 ? {bus.alu_a[0], bus.alu_a[31:1]} : 32'hDEAD_BEEF;
  int total = 0;
  int passed = 0;
  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  st;
    logic [31:0] res;
    logic [3:0]  aop;
  } vec_t;
  vec_t v[11];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", n, act, exp);
    else passed++;
  endtask
  task automatic send(input logic [7:0] d);
    int n = 0;
    bus.in_data = d;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    if (n == 50) begin total++; $display("FAIL send_wait: in_ready stuck low for byte %h", d); end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
  endtask
  task automatic recv(output logic [7:0] d);
    int n = 0;
    bus.out_ready = 1'b1;
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    if (n == 50) begin total++; $display("FAIL recv_wait: out_valid never rose"); end
    d = bus.out_data;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    send(op);
    for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send(b[8*i +: 8]);
  endtask
  task automatic run_vec(input vec_t x, input int idx);
    logic [7:0] d;
    send_frame(x.op, x.a, x.b);
    chk($sformatf("v%0d exec_in_ready", idx), {31'b0, bus.in_ready}, 32'd0);
    recv(d);
    chk($sformatf("v%0d status", idx), {24'b0, d}, {24'b0, x.st});
    chk($sformatf("v%0d alu_op", idx), {28'b0, bus.alu_op}, {28'b0, x.aop});
    chk($sformatf("v%0d alu_a", idx), bus.alu_a, x.a);
    chk($sformatf("v%0d alu_b", idx), bus.alu_b, x.b);
    chk($sformatf("v%0d tx_in_ready", idx), {31'b0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      recv(d);
      chk($sformatf("v%0d res_byte%0d", idx, i), {24'b0, d}, {24'b0, x.res[8*i +: 8]});
    end
    chk($sformatf("v%0d done_out_valid", idx), {31'b0, bus.out_valid}, 32'd0);
    chk($sformatf("v%0d done_in_ready", idx), {31'b0, bus.in_ready}, 32'd1);
  endtask
  initial begin
    logic [7:0] d;
    int first;
    int pulses;
    v[0]  = '{8'h0A, 32'h0000_0001, 32'h0000_0002, 8'h00, 32'h0000_0003, 4'hA};
    v[1]  = '{8'h0B, 32'h0000_0000, 32'h0000_0001, 8'h00, 32'hFFFF_FFFF, 4'hB};
    v[2]  = '{8'h07, 32'h0000_0001, 32'h1234_5678, 8'h00, 32'h8000_0000, 4'h7};
    v[3]  = '{8'h1A, 32'h0000_0005, 32'h0000_0006, 8'h01, 32'h0000_0000, 4'h0};
    v[4]  = '{8'h02, 32'hF0F0_0000, 32'h0000_0F0F, 8'h00, 32'hF0F0_0F0F, 4'h2};
    v[5]  = '{8'h0D, 32'hFF00_FF00, 32'h0F0F_0F0F, 8'h00, 32'h0F00_0F00, 4'hD};
    v[6]  = '{8'h05, 32'hAAAA_5555, 32'hFFFF_0000, 8'h00, 32'h5555_5555, 4'h5};
    v[7]  = '{8'h06, 32'h1234_5678, 32'h1234_5678, 8'h00, 32'hFFFF_FFFF, 4'h6};
    v[8]  = '{8'h0E, 32'h0000_FFFF, 32'h0000_0000, 8'h00, 32'hFFFF_0000, 4'hE};
    v[9]  = '{8'h03, 32'h0000_0001, 32'h0000_0001, 8'h01, 32'h0000_0000, 4'h0};
    v[10] = '{8'h0A, 32'hFFFF_FFFF, 32'h0000_0002, 8'h00, 32'h0000_0001, 4'hA};
    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst out_data", {24'b0, bus.out_data}, 32'd0);
    chk("rst alu_a", bus.alu_a, 32'd0);
    chk("rst alu_b", bus.alu_b, 32'd0);
    chk("rst alu_op", {28'b0, bus.alu_op}, 32'd0);
    chk("rst busy", {31'b0, bus.busy}, 32'd0);
    chk("rst frame_err", {31'b0, bus.frame_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 11; i++) run_vec(v[i], i);
    // backpressure after the second response byte, with a stray inbound byte offered during TX
    send_frame(8'h0A, 32'h1122_3344, 32'h0101_0101);
    recv(d);
    chk("bp status", {24'b0, d}, 32'h00);
    recv(d);
    chk("bp byte0", {24'b0, d}, 32'h45);
    bus.in_data = 8'h0A;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp hold%0d out_valid", i), {31'b0, bus.out_valid}, 32'd1);
      chk($sformatf("bp hold%0d out_data", i), {24'b0, bus.out_data}, 32'h34);
      chk($sformatf("bp hold%0d in_ready", i), {31'b0, bus.in_ready}, 32'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    recv(d);
    chk("bp byte1", {24'b0, d}, 32'h34);
    recv(d);
    chk("bp byte2", {24'b0, d}, 32'h23);
    recv(d);
    chk("bp byte3", {24'b0, d}, 32'h12);
    chk("bp done busy", {31'b0, bus.busy}, 32'd0);
    chk("bp done in_ready", {31'b0, bus.in_ready}, 32'd1);
    run_vec(v[2], 100);
    // partial frame abandoned: frame_err expected after the 8th idle edge
    send(8'h0A);
    send(8'h01);
    send(8'h02);
    first = 0;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.frame_err) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    chk("to pulses", pulses, 32'd1);
    chk("to first_cycle", first, 32'd8);
    chk("to busy", {31'b0, bus.busy}, 32'd0);
    chk("to in_ready", {31'b0, bus.in_ready}, 32'd1);
    run_vec(v[0], 101);
    // reset while the response is being sent
    send_frame(8'h0B, 32'h0000_0000, 32'h0000_0001);
    recv(d);
    chk("rtx status", {24'b0, d}, 32'h00);
    chk("rtx pre out_valid", {31'b0, bus.out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rtx out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rtx in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rtx busy", {31'b0, bus.busy}, 32'd0);
    chk("rtx alu_op", {28'b0, bus.alu_op}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_vec(v[4], 102);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
